// File: rtl/bmsce_magnitude_comparator.sv
// rtl/bmsce_magnitude_comparator.sv - registered 2-bit unsigned magnitude comparator
module bmsce_magnitude_comparator (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [1:0] a;
   logic [1:0] b;
   logic [2:0] flags_next;
   logic [2:0] flags_q;

   assign a = ui_in[1:0];
   assign b = ui_in[3:2];

   // Flag order is {lt, eq, gt}, so exactly one bit is set per compare.
   always_comb begin
      flags_next = 3'b000;
      if (a > b) begin
         flags_next = 3'b001;
      end else if (a == b) begin
         flags_next = 3'b010;
      end else begin
         flags_next = 3'b100;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 3'b000;
      end else if (!ena) begin
         flags_q <= 3'b000;
      end else begin
         flags_q <= flags_next;
      end
   end

   assign uo_out  = {5'b00000, flags_q};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   logic unused_ok;
   assign unused_ok = &{1'b0, ui_in[7:4], uio_in};

endmodule

// File: tb/tb_bmsce_magnitude_comparator.sv
// tb/tb_bmsce_magnitude_comparator.sv - directed self-checking bench for the magnitude comparator
module tb_bmsce_magnitude_comparator;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int tests_run;
   int tests_failed;

   bmsce_magnitude_comparator dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] model(input int a, input int b);
      if (a > b) return 8'h01;
      if (a == b) return 8'h02;
      return 8'h04;
   endfunction

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst    = 1'b1;
      ena    = 1'b1;
      ui_in  = 8'h0D;
      uio_in = 8'h00;

      // Reset held for two edges
      tick();
      tick();
      check("reset_uo_out", uo_out, 8'h00);
      check("reset_uio_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);

      // Exhaustive sweep, one combo per cycle; result checked one edge later
      rst = 1'b0;
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            ui_in = {4'h0, b[1:0], a[1:0]};
            tick();
            check($sformatf("sweep_a%0d_b%0d", a, b), uo_out, model(a, b));
         end
      end

      ui_in = 8'h03;  // A=3,B=0
      tick();
      check("a3_b0_gt", uo_out, 8'h01);
      ui_in = 8'h0A;  // A=2,B=2
      tick();
      check("a2_b2_eq", uo_out, 8'h02);
      ui_in = 8'h0C;  // A=0,B=3
      tick();
      check("a0_b3_lt", uo_out, 8'h04);

      // Don't-care inputs
      ui_in  = 8'hF5;
      uio_in = 8'hFF;
      tick();
      check("dontcare_uo_out", uo_out, 8'h02);
      check("dontcare_uio_out", uio_out, 8'h00);
      check("dontcare_uio_oe", uio_oe, 8'h00);
      uio_in = 8'h00;

      // Enable drop and resume with A=3,B=1
      ui_in = 8'h07;
      tick();
      check("ena_pre", uo_out, 8'h01);
      ena = 1'b0;
      tick();
      check("ena_low", uo_out, 8'h00);
      ena = 1'b1;
      tick();
      check("ena_resume", uo_out, 8'h01);

      // Latency: A 0->3 with B=2
      ui_in = 8'h08;
      tick();
      check("lat_before", uo_out, 8'h04);
      @(negedge clk);
      ui_in = 8'h0B;
      #1;
      check("lat_no_comb_path", uo_out, 8'h04);
      @(posedge clk);
      #1;
      check("lat_after", uo_out, 8'h01);

      // Mid-run reset, uo_out currently 8'h01
      rst = 1'b1;
      tick();
      check("midrst_clear", uo_out, 8'h00);
      rst = 1'b0;
      tick();
      check("midrst_recover", uo_out, 8'h01);

      // Reset overrides enable
      rst = 1'b1;
      ena = 1'b1;
      ui_in = 8'h03;
      tick();
      check("rst_over_ena", uo_out, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
